tgc_sequencer: RTL and testbench

TGC_SEQUENCER -- requirements
Module: tgc_sequencer

---
 rtl/tgc_sequencer_if.sv | 34 +++
 rtl/tgc_sequencer.sv | 158 +++++++++++++++
 tb/tb_tgc_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/tgc_sequencer_if.sv
// ---------------------------------------------------------------------------
// tgc_sequencer_if
// Bundles the control inputs and mode outputs of the traffic-group
// controller sequencer.
//   tick          : one-cycle timing enable
//   start         : leave the initial-load mode
//   load_req      : request a return to the initial-load mode
//   lane_request  : per-lane "cars waiting" flags
//   tgc_out       : mode code (00 load, 01 all-red, 10 green)
//   green_lane    : one-hot lane holding green
//   ticks_left    : remaining ticks in the current timed state
//   mode_change   : single-cycle pulse on the first cycle of a new state
// Modport master drives the inputs; modport slave is the sequencer itself.
// ---------------------------------------------------------------------------
interface tgc_sequencer_if;
  logic       tick;
  logic       start;
  logic       load_req;
  logic [3:0] lane_request;
  logic [1:0] tgc_out;
  logic [3:0] green_lane;
  logic [3:0] ticks_left;
  logic       mode_change;

  modport master (
    output tick, start, load_req, lane_request,
    input  tgc_out, green_lane, ticks_left, mode_change
  );

  modport slave (
    input  tick, start, load_req, lane_request,
    output tgc_out, green_lane, ticks_left, mode_change
  );
endinterface

// File: rtl/tgc_sequencer.sv
// ---------------------------------------------------------------------------
// tgc_sequencer
// Three-mode traffic sequencer: LOAD -> ALL_RED -> GREEN -> ALL_RED -> ...
// Lanes are served round-robin starting after the last lane that was green.
// Ports:
//   clock    : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : tgc_sequencer_if.slave (control inputs, registered outputs)
// Parameters:
//   RED_TICKS   : ticks spent in ALL_RED (0 is treated as 1)
//   GREEN_TICKS : ticks a lane holds green (0 is treated as 1)
// ---------------------------------------------------------------------------
module tgc_sequencer #(
  parameter int unsigned RED_TICKS   = 2,
  parameter int unsigned GREEN_TICKS = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  tgc_sequencer_if.slave   bus
);

  // A zero-length timed state would never expire cleanly, so clamp to 1.
  localparam logic [3:0] RED_T   = (RED_TICKS   == 32'd0) ? 4'd1 : RED_TICKS[3:0];
  localparam logic [3:0] GREEN_T = (GREEN_TICKS == 32'd0) ? 4'd1 : GREEN_TICKS[3:0];

  localparam logic [1:0] CODE_LOAD  = 2'b00;
  localparam logic [1:0] CODE_RED   = 2'b01;
  localparam logic [1:0] CODE_GREEN = 2'b10;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_ALL_RED = 2'd1,
    ST_GREEN   = 2'd2
  } state_t;

  state_t     state_r;
  logic [1:0] last_green_r;
  logic [1:0] tgc_out_r;
  logic [3:0] green_lane_r;
  logic [3:0] ticks_left_r;
  logic       mode_change_r;

  logic [2:0] pick_s;
  logic       lane_found_s;
  logic [1:0] lane_idx_s;
  logic       expire_s;

  // Round-robin search: first requesting lane starting at (last+1) mod 4.
  // Returns {found, index}.
  function automatic logic [2:0] pick_lane(input logic [3:0] req,
                                           input logic [1:0] last);
    logic       found_v;
    logic [1:0] idx_v;
    logic [1:0] cand_v;
    found_v = 1'b0;
    idx_v   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand_v = last + 2'(k);
      if (!found_v && req[cand_v]) begin
        found_v = 1'b1;
        idx_v   = cand_v;
      end else begin
        found_v = found_v;
      end
    end
    return {found_v, idx_v};
  endfunction

  assign pick_s       = pick_lane(bus.lane_request, last_green_r);
  assign lane_found_s = pick_s[2];
  assign lane_idx_s   = pick_s[1:0];
  // Treat ticks_left<=1 as expiry so a corrupted 0 can never wrap to 15.
  assign expire_s     = bus.tick && (ticks_left_r <= 4'd1);

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_LOAD;
      last_green_r  <= 2'd3;
      tgc_out_r     <= CODE_LOAD;
      green_lane_r  <= 4'b0000;
      ticks_left_r  <= 4'd0;
      mode_change_r <= 1'b0;
    end else begin
      mode_change_r <= 1'b0;
      case (state_r)
        ST_LOAD: begin
          if (bus.start && !bus.load_req) begin
            state_r       <= ST_ALL_RED;
            tgc_out_r     <= CODE_RED;
            ticks_left_r  <= RED_T;
            mode_change_r <= 1'b1;
          end else begin
            tgc_out_r     <= CODE_LOAD;
            green_lane_r  <= 4'b0000;
            ticks_left_r  <= 4'd0;
          end
        end

        ST_ALL_RED: begin
          // load_req wins over a coincident expiry.
          if (bus.load_req) begin
            state_r       <= ST_LOAD;
            tgc_out_r     <= CODE_LOAD;
            green_lane_r  <= 4'b0000;
            ticks_left_r  <= 4'd0;
            mode_change_r <= 1'b1;
          end else if (expire_s) begin
            if (lane_found_s) begin
              state_r       <= ST_GREEN;
              tgc_out_r     <= CODE_GREEN;
              green_lane_r  <= 4'b0001 << lane_idx_s;
              ticks_left_r  <= GREEN_T;
              last_green_r  <= lane_idx_s;
              mode_change_r <= 1'b1;
            end else begin
              // Nobody waiting: restart the red interval silently.
              ticks_left_r  <= RED_T;
            end
          end else if (bus.tick) begin
            ticks_left_r <= ticks_left_r - 4'd1;
          end else begin
            ticks_left_r <= ticks_left_r;
          end
        end

        ST_GREEN: begin
          // Green always passes through ALL_RED, whether expired or aborted.
          if (bus.load_req || expire_s) begin
            state_r       <= ST_ALL_RED;
            tgc_out_r     <= CODE_RED;
            green_lane_r  <= 4'b0000;
            ticks_left_r  <= RED_T;
            mode_change_r <= 1'b1;
          end else if (bus.tick) begin
            ticks_left_r <= ticks_left_r - 4'd1;
          end else begin
            ticks_left_r <= ticks_left_r;
          end
        end

        default: begin
          state_r       <= ST_LOAD;
          tgc_out_r     <= CODE_LOAD;
          green_lane_r  <= 4'b0000;
          ticks_left_r  <= 4'd0;
          mode_change_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.tgc_out     = tgc_out_r;
  assign bus.green_lane  = green_lane_r;
  assign bus.ticks_left  = ticks_left_r;
  assign bus.mode_change = mode_change_r;

endmodule

// File: tb/tb_tgc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tgc_sequencer
// Table-driven bench for tgc_sequencer (RED_TICKS=2, GREEN_TICKS=5).
// Each record holds the inputs applied before a clock edge and the outputs
// expected after it; expectations are queued when stimulus is driven and
// popped when the outputs are sampled.
// ---------------------------------------------------------------------------
module tb_tgc_sequencer;

  typedef struct {
    logic       tick;
    logic       start;
    logic       load_req;
    logic [3:0] lanes;
    logic [1:0] tgc;
    logic [3:0] green;
    logic [3:0] ticks;
    logic       mc;
  } vec_t;

  typedef struct {
    logic [1:0] tgc;
    logic [3:0] green;
    logic [3:0] ticks;
    logic       mc;
  } exp_t;

  logic clock;
  logic reset_n;
  int   n_tests;
  int   n_failed;
  exp_t sb_q[$];
  vec_t vecs[$];

  tgc_sequencer_if bus ();

  tgc_sequencer #(.RED_TICKS(2), .GREEN_TICKS(5)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // 10 time-unit clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Mode code 11 must never appear.
  always @(negedge clock) begin
    n_tests++;
    if (bus.tgc_out === 2'b11 || $isunknown(bus.tgc_out)) begin
      n_failed++;
      $display("FAIL tgc_out_illegal got %b", bus.tgc_out);
    end
  end

  task automatic check_out(input string tag, input int idx, input exp_t e);
    n_tests++;
    if (bus.tgc_out !== e.tgc) begin
      n_failed++;
      $display("FAIL %s[%0d] tgc_out got %b exp %b", tag, idx, bus.tgc_out, e.tgc);
    end
    n_tests++;
    if (bus.green_lane !== e.green) begin
      n_failed++;
      $display("FAIL %s[%0d] green_lane got %b exp %b", tag, idx, bus.green_lane, e.green);
    end
    n_tests++;
    if (bus.ticks_left !== e.ticks) begin
      n_failed++;
      $display("FAIL %s[%0d] ticks_left got %0d exp %0d", tag, idx, bus.ticks_left, e.ticks);
    end
    n_tests++;
    if (bus.mode_change !== e.mc) begin
      n_failed++;
      $display("FAIL %s[%0d] mode_change got %b exp %b", tag, idx, bus.mode_change, e.mc);
    end
  endtask

  // Drive one vector, queue its expectation, clock it, then sample and compare.
  task automatic apply(input vec_t v, input string tag, input int idx);
    exp_t e;
    bus.tick         = v.tick;
    bus.start        = v.start;
    bus.load_req     = v.load_req;
    bus.lane_request = v.lanes;
    e = '{v.tgc, v.green, v.ticks, v.mc};
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    check_out(tag, idx, e);
  endtask

  task automatic add(input logic t, input logic s, input logic l,
                     input logic [3:0] ln, input logic [1:0] tg,
                     input logic [3:0] gr, input logic [3:0] tk,
                     input logic mc);
    vec_t v;
    v = '{t, s, l, ln, tg, gr, tk, mc};
    vecs.push_back(v);
  endtask

  initial begin
    exp_t e;
    vec_t v;
    n_tests  = 0;
    n_failed = 0;
    reset_n          = 1'b0;
    bus.tick         = 1'b0;
    bus.start        = 1'b0;
    bus.load_req     = 1'b0;
    bus.lane_request = 4'b0000;

    //  t     s     l     lanes    tgc    green    ticks mc
    // LOAD, start ignored while load_req, then enter ALL_RED
    add(1'b0, 1'b0, 1'b0, 4'b0001, 2'b00, 4'b0000, 4'd0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 4'b0001, 2'b00, 4'b0000, 4'd0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'b0001, 2'b01, 4'b0000, 4'd2, 1'b1);
    add(1'b0, 1'b0, 1'b0, 4'b0001, 2'b01, 4'b0000, 4'd2, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'b0001, 2'b01, 4'b0000, 4'd1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 4'b0001, 2'b01, 4'b0000, 4'd1, 1'b0);
    // red expiry -> lane 0 green; lane_request changes do not move green
    add(1'b1, 1'b0, 1'b0, 4'b0001, 2'b10, 4'b0001, 4'd5, 1'b1);
    add(1'b1, 1'b0, 1'b0, 4'b0001, 2'b10, 4'b0001, 4'd4, 1'b0);
    add(1'b0, 1'b0, 1'b0, 4'b0000, 2'b10, 4'b0001, 4'd4, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'b1110, 2'b10, 4'b0001, 4'd3, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'b0000, 2'b10, 4'b0001, 4'd2, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'b0000, 2'b10, 4'b0001, 4'd1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'b0000, 2'b01, 4'b0000, 4'd2, 1'b1);
    // lanes 1010: lane 1, then lane 3, then wrap to lane 1
    add(1'b1, 1'b0, 1'b0, 4'b1010, 2'b01, 4'b0000, 4'd1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'b1010, 2'b10, 4'b0010, 4'd5, 1'b1);
    add(1'b1, 1'b0, 1'b0, 4'b1010, 2'b10, 4'b0010, 4'd4, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'b1010, 2'b10, 4'b0010, 4'd3, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'b1010, 2'b10, 4'b0010, 4'd2, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'b1010, 2'b10, 4'b0010, 4'd1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'b1010, 2'b01, 4'b0000, 4'd2, 1'b1);
    add(1'b1, 1'b0, 1'b0, 4'b1010, 2'b01, 4'b0000, 4'd1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'b1010, 2'b10, 4'b1000, 4'd5, 1'b1);
    add(1'b1, 1'b0, 1'b0, 4'b1010, 2'b10, 4'b1000, 4'd4, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'b1010, 2'b10, 4'b1000, 4'd3, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'b1010, 2'b10, 4'b1000, 4'd2, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'b1010, 2'b10, 4'b1000, 4'd1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'b1010, 2'b01, 4'b0000, 4'd2, 1'b1);
    add(1'b1, 1'b0, 1'b0, 4'b1010, 2'b01, 4'b0000, 4'd1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'b1010, 2'b10, 4'b0010, 4'd5, 1'b1);
    // load_req mid-green with ticks_left=3 -> ALL_RED, then LOAD
    add(1'b1, 1'b0, 1'b0, 4'b1010, 2'b10, 4'b0010, 4'd4, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'b1010, 2'b10, 4'b0010, 4'd3, 1'b0);
    add(1'b0, 1'b0, 1'b1, 4'b1010, 2'b01, 4'b0000, 4'd2, 1'b1);
    add(1'b0, 1'b0, 1'b1, 4'b1010, 2'b00, 4'b0000, 4'd0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 4'b1010, 2'b00, 4'b0000, 4'd0, 1'b0);
    // no lanes requesting: three silent red reloads
    add(1'b0, 1'b1, 1'b0, 4'b0000, 2'b01, 4'b0000, 4'd2, 1'b1);
    add(1'b1, 1'b0, 1'b0, 4'b0000, 2'b01, 4'b0000, 4'd1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'b0000, 2'b01, 4'b0000, 4'd2, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'b0000, 2'b01, 4'b0000, 4'd1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'b0000, 2'b01, 4'b0000, 4'd2, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'b0000, 2'b01, 4'b0000, 4'd1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'b0000, 2'b01, 4'b0000, 4'd2, 1'b0);
    // load_req coincident with red expiry -> LOAD, not GREEN
    add(1'b1, 1'b0, 1'b0, 4'b1111, 2'b01, 4'b0000, 4'd1, 1'b0);
    add(1'b1, 1'b0, 1'b1, 4'b1111, 2'b00, 4'b0000, 4'd0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 4'b1111, 2'b00, 4'b0000, 4'd0, 1'b0);
    // last green was 1: lanes 0100 -> lane 2
    add(1'b0, 1'b1, 1'b0, 4'b0100, 2'b01, 4'b0000, 4'd2, 1'b1);
    add(1'b1, 1'b0, 1'b0, 4'b0100, 2'b01, 4'b0000, 4'd1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'b0100, 2'b10, 4'b0100, 4'd5, 1'b1);

    // Reset state
    @(posedge clock);
    @(posedge clock);
    #1;
    e = '{2'b00, 4'b0000, 4'd0, 1'b0};
    check_out("reset", 0, e);
    #2 reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], "vec", i);
    end

    // Asynchronous reset mid-green: outputs drop before the next edge.
    #3 reset_n = 1'b0;
    #1;
    e = '{2'b00, 4'b0000, 4'd0, 1'b0};
    check_out("async_rst", 0, e);
    @(posedge clock);
    #3 reset_n = 1'b1;

    // Stays in LOAD until start; search restarts at lane 0.
    v = '{1'b1, 1'b0, 1'b0, 4'b1111, 2'b00, 4'b0000, 4'd0, 1'b0};
    apply(v, "post_rst", 0);
    v = '{1'b1, 1'b0, 1'b0, 4'b1111, 2'b00, 4'b0000, 4'd0, 1'b0};
    apply(v, "post_rst", 1);
    v = '{1'b0, 1'b1, 1'b0, 4'b1111, 2'b01, 4'b0000, 4'd2, 1'b1};
    apply(v, "post_rst", 2);
    v = '{1'b1, 1'b0, 1'b0, 4'b1111, 2'b01, 4'b0000, 4'd1, 1'b0};
    apply(v, "post_rst", 3);
    v = '{1'b1, 1'b0, 1'b0, 4'b1111, 2'b10, 4'b0001, 4'd5, 1'b1};
    apply(v, "post_rst", 4);

    // Tick every fourth cycle: counter holds between ticks.
    for (int i = 0; i < 8; i++) begin
      v = '{(i % 4 == 3) ? 1'b1 : 1'b0, 1'b0, 1'b0, 4'b1111, 2'b10, 4'b0001,
            (i < 3) ? 4'd5 : ((i < 7) ? 4'd4 : 4'd3), 1'b0};
      apply(v, "slow_tick", i);
    end

    n_tests++;
    if (sb_q.size() != 0) begin
      n_failed++;
      $display("FAIL scoreboard_drain got %0d exp 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
